wb_sram_port0_ctrl: RTL and testbench

Wishbone classic slave that owns the read/write port (port 0) of the 1 KB SKY130 SRAM macro (32 × 256). It sits directly upstream of the macro, between the SoC Wishbone interconnect and the macro's clk0/csb0/web0/wmask0/addr0/din0/dout0 pins. It turns single Wishbone transfers into one-shot SRAM accesses with registered macro controls, handles the macro's configurable read latency, and flags out-of-window addresses. Port 1 (read-only) is not driven by this block.

---
 rtl/wb_sram_port0_ctrl.sv | 173 +++++++++++++++++
 tb/tb_wb_sram_port0_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_port0_ctrl.sv
// wb_sram_port0_ctrl: Wishbone classic slave that owns the read/write port
// of the 32x256 SKY130 SRAM macro, with registered macro controls.
module wb_sram_port0_ctrl #(
    parameter int AW          = 8,
    parameter int RD_LAT      = 1,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          sram_csb0,
    output logic          sram_web0,
    output logic [7:0]    sram_wmask0,
    output logic [AW-1:0] sram_addr0,
    output logic [31:0]   sram_din0,
    input  logic [31:0]   sram_dout0
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        ACK,
        ERR
    } state_t;

    // Counter preload: edges left to wait after the macro capture edge.
    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t        state;
    state_t        state_d;
    logic [1:0]    cnt;
    logic [1:0]    cnt_d;
    logic          abrt;
    logic          abrt_d;
    logic          csb_d;
    logic          web_d;
    logic          ack_d;
    logic          err_d;
    logic          ld_dat;
    logic [7:0]    wmask_d;
    logic [AW-1:0] addr_d;
    logic [31:0]   din_d;
    logic          req;
    logic          oor;
    logic          unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign oor        = CHECK_RANGE && (wb_adr_i[31:AW+2] != '0);
    assign unused_adr = ^wb_adr_i[1:0];

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        abrt_d  = abrt;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ld_dat  = 1'b0;
        wmask_d = sram_wmask0;
        addr_d  = sram_addr0;
        din_d   = sram_din0;
        unique case (state)
            IDLE: begin
                abrt_d = 1'b0;
                if (req) begin
                    if (oor) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else if (wb_we_i) begin
                        addr_d  = wb_adr_i[AW+1:2];
                        din_d   = wb_dat_i;
                        wmask_d = {4'b0000, wb_sel_i};
                        csb_d   = 1'b0;
                        web_d   = 1'b0;
                        state_d = WR;
                    end else begin
                        addr_d  = wb_adr_i[AW+1:2];
                        wmask_d = 8'h00;
                        csb_d   = 1'b0;
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR: begin
                // The macro takes the write on this edge regardless;
                // a dropped cycle only loses the acknowledge.
                ack_d   = wb_cyc_i;
                state_d = wb_cyc_i ? ACK : IDLE;
            end
            RD_ISSUE: begin
                cnt_d   = LAT_M1;
                abrt_d  = abrt | ~wb_cyc_i;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                abrt_d = abrt | ~wb_cyc_i;
                if (cnt != 2'd0) begin
                    cnt_d = cnt - 2'd1;
                end else begin
                    // Data is captured even for an abandoned read.
                    ld_dat  = 1'b1;
                    ack_d   = ~abrt_d;
                    state_d = abrt_d ? IDLE : ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, latency counter and abort flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
            abrt  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            abrt  <= abrt_d;
        end
    end

    // Registered macro pins and bus handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= 8'h00;
            sram_addr0  <= '0;
            sram_din0   <= 32'h0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
        end else begin
            sram_csb0   <= csb_d;
            sram_web0   <= web_d;
            sram_wmask0 <= wmask_d;
            sram_addr0  <= addr_d;
            sram_din0   <= din_d;
            wb_ack_o    <= ack_d;
            wb_err_o    <= err_d;
        end
    end

    // Read data register, loaded once the macro output has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_dat_o <= 32'h0;
        end else if (ld_dat) begin
            wb_dat_o <= sram_dout0;
        end
    end

endmodule

// File: tb/tb_wb_sram_port0_ctrl.sv
// tb_wb_sram_port0_ctrl: randomized self-checking bench driving two
// controllers (read latency 1 and 3) against a word-level memory model.
module tb_wb_sram_port0_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] dati [2];
    logic [3:0]  sel  [2];
    logic [31:0] dato [2];
    logic        ack  [2];
    logic        err  [2];
    logic        csb  [2];
    logic        web  [2];
    logic [7:0]  wm   [2];
    logic [7:0]  sa   [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];

    logic [31:0] mem  [2][256];
    logic [31:0] pipe [2][3];

    logic [31:0] ref_mem [2][256];
    bit          ref_val [2][256];
    int          csblow  [2];

    int          vectors;
    int          miscompares;

    int          r_lat;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic        c1_csb;
    logic        c1_web;
    logic [7:0]  c1_wm;
    logic [7:0]  c1_sa;

    wb_sram_port0_ctrl #(
        .AW(8), .RD_LAT(1), .CHECK_RANGE(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_dat_i(dati[0]), .wb_sel_i(sel[0]),
        .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]),
        .sram_csb0(csb[0]), .sram_web0(web[0]), .sram_wmask0(wm[0]),
        .sram_addr0(sa[0]), .sram_din0(din[0]), .sram_dout0(dout[0])
    );

    wb_sram_port0_ctrl #(
        .AW(8), .RD_LAT(3), .CHECK_RANGE(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(dati[1]), .wb_sel_i(sel[1]),
        .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]),
        .sram_csb0(csb[1]), .sram_web0(web[1]), .sram_wmask0(wm[1]),
        .sram_addr0(sa[1]), .sram_din0(din[1]), .sram_dout0(dout[1])
    );

    always #5 clk = ~clk;

    // Macro model: data appears RD_LAT edges after capture, garbage otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!csb[d] && !web[d])
                for (int b = 0; b < 4; b++)
                    if (wm[d][b]) mem[d][sa[d]][8*b +: 8] <= din[d][8*b +: 8];
            pipe[d][0] <= (!csb[d] && web[d]) ? mem[d][sa[d]] : $urandom;
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign dout[0] = pipe[0][0];
    assign dout[1] = pipe[1][2];

    // Count chip-select-low clocks per macro.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (rst_n && !csb[d]) csblow[d] <= csblow[d] + 1;
    end

    function automatic logic [31:0] adr_of(input logic [7:0] w);
        adr_of = {22'd0, w, 2'b00};
    endfunction

    function automatic void ref_write(input int d, input logic [7:0] w,
                                      input logic [31:0] v,
                                      input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[d][w][8*b +: 8] = v[8*b +: 8];
        ref_val[d][w] = 1'b1;
    endfunction

    // One Wishbone transfer; ends one edge after the handshake.
    task automatic bus(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] v, input logic [3:0] s);
        int n;
        n = 0;
        r_lat = 0;
        r_ack = 1'b0;
        r_err = 1'b0;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        adr[d] = a; dati[d] = v; sel[d] = s;
        while (r_lat == 0 && n < 20) begin
            n++;
            @(posedge clk); #1;
            if (n == 1) begin
                c1_csb = csb[d]; c1_web = web[d];
                c1_wm = wm[d]; c1_sa = sa[d];
            end
            if (ack[d] || err[d]) begin
                r_ack = ack[d]; r_err = err[d];
                r_dat = dato[d]; r_lat = n;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        vectors++;
        if (r_lat == 0) begin
            miscompares++;
            $display("FAIL bus_timeout dut%0d adr=%h", d, a);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({csb[d], web[d], ack[d], err[d]} !== 4'b1100) begin
                miscompares++;
                $display("FAIL rst_ctl dut%0d got=%b exp=1100", d,
                         {csb[d], web[d], ack[d], err[d]});
            end
            vectors++;
            if ({wm[d], sa[d], din[d], dato[d]} !== 80'h0) begin
                miscompares++;
                $display("FAIL rst_data dut%0d wm=%h sa=%h din=%h dat=%h exp=0",
                         d, wm[d], sa[d], din[d], dato[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        bus(0, 1'b1, 32'h0000_03FC, 32'hDEADBEEF, 4'hF);
        ref_write(0, 8'hFF, 32'hDEADBEEF, 4'hF);
        vectors++;
        if ({c1_csb, c1_web, c1_wm, c1_sa} !== {2'b00, 8'h0F, 8'hFF}) begin
            miscompares++;
            $display("FAIL wr_pins csb=%b web=%b wm=%h sa=%h exp=0 0 0f ff",
                     c1_csb, c1_web, c1_wm, c1_sa);
        end
        vectors++;
        if (r_lat != 2 || r_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_lat got=%0d ack=%b exp=2 ack=1", r_lat, r_ack);
        end
        bus(0, 1'b0, 32'h0000_03FC, 32'h0, 4'h0);
        vectors++;
        if ({c1_csb, c1_web, c1_wm} !== {2'b01, 8'h00}) begin
            miscompares++;
            $display("FAIL rd_pins csb=%b web=%b wm=%h exp=0 1 00",
                     c1_csb, c1_web, c1_wm);
        end
        vectors++;
        if (r_lat != 3 || r_dat !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_lat1 lat=%0d dat=%h exp=3 deadbeef", r_lat, r_dat);
        end
    endtask

    task automatic test_byte_lanes;
        bus(0, 1'b1, adr_of(8'd0), 32'h11223344, 4'hF);
        ref_write(0, 8'd0, 32'h11223344, 4'hF);
        bus(0, 1'b1, adr_of(8'd0), 32'hAABBCCDD, 4'b0101);
        ref_write(0, 8'd0, 32'hAABBCCDD, 4'b0101);
        bus(0, 1'b0, adr_of(8'd0), 32'h0, 4'h0);
        vectors++;
        if (r_dat !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL byte_lanes got=%h exp=11bb33dd", r_dat);
        end
        bus(0, 1'b1, adr_of(8'd0), 32'h0BADF00D, 4'h0);
        bus(0, 1'b0, adr_of(8'd0), 32'h0, 4'h0);
        vectors++;
        if (r_dat !== ref_mem[0][0]) begin
            miscompares++;
            $display("FAIL sel_zero got=%h exp=%h", r_dat, ref_mem[0][0]);
        end
    endtask

    task automatic test_range;
        int c0;
        c0 = csblow[0];
        bus(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0);
        vectors++;
        if (r_lat != 1 || {r_ack, r_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL range_rd lat=%0d ack=%b err=%b exp=1 0 1",
                     r_lat, r_ack, r_err);
        end
        bus(0, 1'b1, 32'hFFFF_FFF0, 32'h12345678, 4'hF);
        vectors++;
        if ({r_ack, r_err} !== 2'b01) begin
            miscompares++;
            $display("FAIL range_wr ack=%b err=%b exp=0 1", r_ack, r_err);
        end
        vectors++;
        if (csblow[0] != c0) begin
            miscompares++;
            $display("FAIL range_csb got=%0d exp=0", csblow[0] - c0);
        end
    endtask

    task automatic test_latency;
        logic [31:0] v;
        int c0;
        v = $urandom;
        bus(1, 1'b1, adr_of(8'd100), v, 4'hF);
        ref_write(1, 8'd100, v, 4'hF);
        c0 = csblow[1];
        for (int i = 0; i < 3; i++) begin
            bus(1, 1'b0, adr_of(8'd100), 32'h0, 4'h0);
            vectors++;
            if (r_lat != 5 || r_dat !== ref_mem[1][100]) begin
                miscompares++;
                $display("FAIL rd_lat3 lat=%0d dat=%h exp=5 %h",
                         r_lat, r_dat, ref_mem[1][100]);
            end
        end
        vectors++;
        if (csblow[1] - c0 != 3) begin
            miscompares++;
            $display("FAIL lat3_csb got=%0d exp=3", csblow[1] - c0);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        int acks;
        logic [31:0] v;
        v = $urandom;
        c0 = csblow[0];
        acks = 0;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
        adr[0] = adr_of(8'd20); dati[0] = v; sel[0] = 4'hF;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            if (ack[0]) acks++;
        end
        ref_write(0, 8'd20, v, 4'hF);
        vectors++;
        if (acks != 3 || csblow[0] - c0 != 3) begin
            miscompares++;
            $display("FAIL b2b_wr acks=%0d csb=%0d exp=3 3", acks, csblow[0] - c0);
        end
        c0 = csblow[0];
        acks = 0;
        we[0] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (ack[0]) begin
                acks++;
                vectors++;
                if (dato[0] !== v) begin
                    miscompares++;
                    $display("FAIL b2b_rd_dat got=%h exp=%h", dato[0], v);
                end
            end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        vectors++;
        if (acks != 3 || csblow[0] - c0 != 3) begin
            miscompares++;
            $display("FAIL b2b_rd acks=%0d csb=%0d exp=3 3", acks, csblow[0] - c0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        int acks;
        logic [31:0] v;
        v = $urandom | 32'h1;
        bus(0, 1'b1, adr_of(8'd33), v, 4'hF);
        ref_write(0, 8'd33, v, 4'hF);
        acks = 0;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = adr_of(8'd33);
        @(posedge clk); #1;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack[0]) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL abort_ack got=%0d exp=0", acks);
        end
        vectors++;
        if (dato[0] !== v) begin
            miscompares++;
            $display("FAIL abort_dat got=%h exp=%h", dato[0], v);
        end
        v = ~v;
        bus(0, 1'b1, adr_of(8'd34), v, 4'hF);
        ref_write(0, 8'd34, v, 4'hF);
        vectors++;
        if (r_lat != 2 || r_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_next lat=%0d ack=%b exp=2 1", r_lat, r_ack);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 80; i++) begin
            int d;
            int c0;
            int el;
            bit w;
            bit oor;
            logic [7:0] wd;
            logic [31:0] a;
            logic [31:0] v;
            logic [3:0] s;
            d = int'($urandom_range(0, 1));
            oor = ($urandom_range(0, 7) == 0);
            w = 1'($urandom_range(0, 1));
            wd = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            v = $urandom;
            s = 4'($urandom);
            a = adr_of(wd);
            a[1:0] = 2'($urandom);
            if (oor) a[31:10] = 22'($urandom_range(1, 32'h3FFFFF));
            c0 = csblow[d];
            bus(d, w, a, v, s);
            el = oor ? 1 : (w ? 2 : 2 + (d == 1 ? 3 : 1));
            vectors++;
            if (r_lat != el) begin
                miscompares++;
                $display("FAIL rnd_lat i=%0d dut%0d got=%0d exp=%0d", i, d, r_lat, el);
            end
            vectors++;
            if ({r_ack, r_err} !== (oor ? 2'b01 : 2'b10)) begin
                miscompares++;
                $display("FAIL rnd_resp i=%0d ack=%b err=%b oor=%0d",
                         i, r_ack, r_err, oor);
            end
            vectors++;
            if (csblow[d] - c0 != (oor ? 0 : 1)) begin
                miscompares++;
                $display("FAIL rnd_csb i=%0d got=%0d exp=%0d",
                         i, csblow[d] - c0, oor ? 0 : 1);
            end
            if (!oor && w) ref_write(d, wd, v, s);
            if (!oor && !w && ref_val[d][wd]) begin
                vectors++;
                if (r_dat !== ref_mem[d][wd]) begin
                    miscompares++;
                    $display("FAIL rnd_dat i=%0d dut%0d got=%h exp=%h",
                             i, d, r_dat, ref_mem[d][wd]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int acks;
        bus(0, 1'b1, adr_of(8'd7), 32'hCAFEF00D, 4'hF);
        bus(0, 1'b0, adr_of(8'd7), 32'h0, 4'h0);
        vectors++;
        if (r_dat !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL rstmid_pre got=%h exp=cafef00d", r_dat);
        end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = adr_of(8'd7);
        @(posedge clk); #1;
        vectors++;
        if (csb[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_issue csb=%b exp=0", csb[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({csb[0], web[0], ack[0], dato[0]} !== {3'b110, 32'h0}) begin
            miscompares++;
            $display("FAIL rstmid csb=%b web=%b ack=%b dat=%h exp=1 1 0 0",
                     csb[0], web[0], ack[0], dato[0]);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack[0] || err[0]) acks++;
        end
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL rstmid_stray got=%0d exp=0", acks);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        vectors = 0;
        miscompares = 0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = 32'h0; dati[d] = 32'h0; sel[d] = 4'h0;
            csblow[d] = 0;
        end
        #2 rst_n = 1'b0;
        test_reset;
        test_write_read;
        test_byte_lanes;
        test_range;
        test_latency;
        test_back_to_back;
        test_abort;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
